// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select,
// load funct3 codes and the buffer state machine.
package wb_pkg;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;
   localparam logic [1:0] WB_SEL_CSR = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      WAIT_LOAD
   } wb_state_e;

   function automatic logic is_load(input logic [1:0] sel);
      return sel == WB_SEL_MEM;
   endfunction

endpackage

// File: rtl/wb_stage_buffered_extract.sv
// Load data extraction: picks byte/half/word at the byte offset of the
// raw memory word and sign- or zero-extends it to XLEN.
module wb_load_extract
   import wb_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [2:0]                 funct3,
   input  logic [$clog2(XLEN/8)-1:0]  offset,
   input  logic [XLEN-1:0]            rdata,
   output logic [XLEN-1:0]            value
);

   localparam int OW = $clog2(XLEN/8);

   logic [OW-1:0]   h_off;
   logic [OW-1:0]   w_off;
   logic [7:0]      b;
   logic [15:0]     h;
   logic [31:0]     w;
   logic [XLEN-1:0] w_sx;
   logic [XLEN-1:0] w_zx;

   // halfword ignores bit0, word ignores bits [1:0] of the offset
   assign h_off = offset & ~OW'(1);
   assign w_off = offset & ~OW'(3);

   assign b = 8'(rdata >> {offset, 3'b000});
   assign h = 16'(rdata >> {h_off, 3'b000});
   assign w = 32'(rdata >> {w_off, 3'b000});

   generate
      if (XLEN == 64) begin : g_rv64
         assign w_sx = {{32{w[31]}}, w};
         assign w_zx = {32'b0, w};
      end else begin : g_rv32
         assign w_sx = w;
         assign w_zx = w;
      end
   endgenerate

   // size/sign decode; unknown codes return the full word
   always_comb begin
      value = rdata;
      unique case (funct3)
         F3_LB:   value = {{(XLEN-8){b[7]}}, b};
         F3_LBU:  value = {{(XLEN-8){1'b0}}, b};
         F3_LH:   value = {{(XLEN-16){h[15]}}, h};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, h};
         F3_LW:   value = w_sx;
         F3_LWU:  value = w_zx;
         F3_LD:   value = rdata;
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage_buffered.sv
// Buffered write-back stage: single-entry buffer, load wait, result mux.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage_buffered
   import wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_wb_sel,
   input  logic              in_reg_write,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [2:0]        in_funct3,
   input  logic [XLEN-1:0]   in_alu_out,
   input  logic [XLEN-1:0]   in_pc_plus4,
   input  logic [XLEN-1:0]   in_csr_rdata,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              load_pending,
`ifdef WB_INSTRET_EN
   output logic [63:0]       instret,
`endif
   output logic [REG_AW-1:0] load_rd
);

   localparam int OW = $clog2(XLEN/8);

   wb_state_e state;
   wb_state_e state_nx;

   logic [1:0]        b_sel;
   logic              b_rw;
   logic [REG_AW-1:0] b_rd;
   logic [2:0]        b_f3;
   logic [XLEN-1:0]   b_alu;
   logic [XLEN-1:0]   b_pc4;
   logic [XLEN-1:0]   b_csr;

   logic              accept;
   logic              retire;
   logic [XLEN-1:0]   ld_val;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // single-entry buffer, loaded on every accepted handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_sel <= WB_SEL_ALU;
         b_rw  <= 1'b0;
         b_rd  <= '0;
         b_f3  <= '0;
         b_alu <= '0;
         b_pc4 <= '0;
         b_csr <= '0;
      end else if (accept) begin
         b_sel <= in_wb_sel;
         b_rw  <= in_reg_write;
         b_rd  <= in_rd;
         b_f3  <= in_funct3;
         b_alu <= in_alu_out;
         b_pc4 <= in_pc_plus4;
         b_csr <= in_csr_rdata;
      end
   end

   // handshake, retirement and next state; a response in WAIT_LOAD
   // frees the buffer in the same cycle for a zero-bubble hand-off
   always_comb begin
      state_nx     = state;
      in_ready     = 1'b1;
      retire       = 1'b0;
      load_pending = 1'b0;
      accept       = 1'b0;
      unique case (state)
         IDLE: begin
            retire = 1'b0;
         end
         WRITE: begin
            retire = 1'b1;
         end
         WAIT_LOAD: begin
            in_ready     = dmem_rsp_valid;
            retire       = dmem_rsp_valid;
            load_pending = 1'b1;
         end
         default: begin
            retire = 1'b0;
         end
      endcase
      accept = in_valid && in_ready;
      if (accept) begin
         state_nx = is_load(in_wb_sel) ? WAIT_LOAD : WRITE;
      end else if (state == WAIT_LOAD && !dmem_rsp_valid) begin
         state_nx = WAIT_LOAD;
      end else begin
         state_nx = IDLE;
      end
   end

   wb_load_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .funct3 (b_f3),
      .offset (b_alu[OW-1:0]),
      .rdata  (dmem_rdata),
      .value  (ld_val)
   );

   // register-file port and hazard outputs straight from the buffer
   always_comb begin
      rf_we    = retire && b_rw && (b_rd != '0);
      rf_waddr = b_rd;
      load_rd  = load_pending ? b_rd : '0;
      rf_wdata = b_alu;
      unique case (b_sel)
         WB_SEL_ALU: rf_wdata = b_alu;
         WB_SEL_MEM: rf_wdata = ld_val;
         WB_SEL_PC4: rf_wdata = b_pc4;
         WB_SEL_CSR: rf_wdata = b_csr;
         default:    rf_wdata = b_alu;
      endcase
   end

`ifdef WB_INSTRET_EN
   // count every retirement, including ones that do not write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Scoreboard bench for wb_stage_buffered (XLEN=32): directed ops push
// expected register writes; a negedge monitor pops and compares them.
module tb_wb_stage_buffered;
   import wb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_wb_sel;
   logic        in_reg_write;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_out;
   logic [31:0] in_pc_plus4;
   logic [31:0] in_csr_rdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        load_pending;
   logic [4:0]  load_rd;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
`endif

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   ret_cnt = 0;

   wb_stage_buffered #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_wb_sel      (in_wb_sel),
      .in_reg_write   (in_reg_write),
      .in_rd          (in_rd),
      .in_funct3      (in_funct3),
      .in_alu_out     (in_alu_out),
      .in_pc_plus4    (in_pc_plus4),
      .in_csr_rdata   (in_csr_rdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .load_pending   (load_pending),
`ifdef WB_INSTRET_EN
      .instret        (instret),
`endif
      .load_rd        (load_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   // monitor: every register write must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: actual addr=%0d data=%h required no write",
                     rf_waddr, rf_wdata);
         end else begin
            m_e = sb_q.pop_front();
            if (rf_waddr !== m_e.addr || rf_wdata !== m_e.data || cyc != m_e.cyc) begin
               errors++;
               $display("FAIL %s: actual addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                        m_e.name, rf_waddr, rf_wdata, cyc, m_e.addr, m_e.data, m_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic push_exp(input string nm, input logic [4:0] a, input logic [31:0] d, input int c);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present a non-load op for one capture edge (caller steps)
   task automatic op(input string nm, input logic [1:0] sel, input logic rw,
                     input logic [4:0] rd, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic [31:0] csr,
                     input logic exp_we, input logic [31:0] exp_d);
      in_wb_sel    = sel;
      in_reg_write = rw;
      in_rd        = rd;
      in_funct3    = F3_LW;
      in_alu_out   = alu;
      in_pc_plus4  = pc4;
      in_csr_rdata = csr;
      in_valid     = 1'b1;
      ret_cnt++;
      if (exp_we) push_exp(nm, rd, exp_d, cyc + 1);
   endtask

   task automatic load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                       input logic rw, input logic [4:0] rd, input logic [31:0] rdata,
                       input int wait_n, input logic exp_we, input logic [31:0] exp_d,
                       input logic spur, input logic follow);
      in_wb_sel    = WB_SEL_MEM;
      in_reg_write = rw;
      in_rd        = rd;
      in_funct3    = f3;
      in_alu_out   = addr;
      in_pc_plus4  = 32'h0;
      in_csr_rdata = 32'h0;
      in_valid     = 1'b1;
      if (spur) begin
         dmem_rsp_valid = 1'b1;
         dmem_rdata     = 32'hDEADBEEF;
      end
      step();
      in_valid       = 1'b0;
      dmem_rsp_valid = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk({nm, "_pending"}, load_pending, 1);
         chk({nm, "_stall"}, in_ready, 0);
         chk({nm, "_load_rd"}, load_rd, rd);
         step();
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = rdata;
      ret_cnt++;
      if (exp_we) push_exp(nm, rd, exp_d, cyc);
      if (follow) op({nm, "_follow"}, WB_SEL_ALU, 1'b1, 5'd9, 32'h00000ABC,
                     32'h0, 32'h0, 1'b1, 32'h00000ABC);
      @(negedge clk);
      chk({nm, "_ready_rsp"}, in_ready, 1);
      step();
      dmem_rsp_valid = 1'b0;
      in_valid       = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      in_wb_sel      = '0;
      in_reg_write   = 1'b0;
      in_rd          = '0;
      in_funct3      = '0;
      in_alu_out     = '0;
      in_pc_plus4    = '0;
      in_csr_rdata   = '0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_load_pending", load_pending, 0);
      chk("rst_load_rd", load_rd, 0);
`ifdef WB_INSTRET_EN
      chk("rst_instret", instret, 0);
`endif
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      step();

      op("alu", WB_SEL_ALU, 1'b1, 5'd5, 32'h12345678, 32'h200, 32'h300,
         1'b1, 32'h12345678);
      step();
      in_valid = 1'b0;
      step();

      load("lb", F3_LB, 32'h1003, 1'b1, 5'd6, 32'h80FF0000, 1, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0);
      load("lbu", F3_LBU, 32'h1003, 1'b1, 5'd7, 32'h80FF0000, 1, 1'b1, 32'h00000080, 1'b0, 1'b0);
      load("lh", F3_LH, 32'h1002, 1'b1, 5'd8, 32'h80FF0000, 2, 1'b1, 32'hFFFF80FF, 1'b0, 1'b0);
      load("lh_odd", F3_LH, 32'h1003, 1'b1, 5'd8, 32'h80FF0000, 1, 1'b1, 32'hFFFF80FF, 1'b0, 1'b0);
      load("lhu", F3_LHU, 32'h1002, 1'b1, 5'd9, 32'h80FF0000, 1, 1'b1, 32'h000080FF, 1'b0, 1'b0);
      load("lw", F3_LW, 32'h1000, 1'b1, 5'd10, 32'h80FF0000, 0, 1'b1, 32'h80FF0000, 1'b0, 1'b0);
      load("lb_pos", F3_LB, 32'h1000, 1'b1, 5'd11, 32'h1234567F, 1, 1'b1, 32'h0000007F, 1'b0, 1'b0);
      load("lh_lo", F3_LH, 32'h1000, 1'b1, 5'd11, 32'h1234F00D, 1, 1'b1, 32'hFFFFF00D, 1'b0, 1'b0);
      load("f3_111", 3'b111, 32'h1001, 1'b1, 5'd12, 32'hCAFEBABE, 1, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0);

      load("stall", F3_LW, 32'h2000, 1'b1, 5'd12, 32'h55AA55AA, 3, 1'b1, 32'h55AA55AA, 1'b0, 1'b1);
      step();

      op("alu_rd0", WB_SEL_ALU, 1'b1, 5'd0, 32'h1111, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("alu_rd0_we", rf_we, 0);
      step();
      load("ld_rd0", F3_LW, 32'h0, 1'b1, 5'd0, 32'h99, 1, 1'b0, 32'h0, 1'b0, 1'b0);
      op("alu_norw", WB_SEL_ALU, 1'b0, 5'd4, 32'h2222, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      step();
`ifdef WB_INSTRET_EN
      chk("instret_count", instret, 64'(ret_cnt));
`endif

      op("b2b_alu", WB_SEL_ALU, 1'b1, 5'd1, 32'h0000A5A5, 32'h0, 32'h0, 1'b1, 32'h0000A5A5);
      step();
      op("b2b_jal", WB_SEL_PC4, 1'b1, 5'd2, 32'h00000100, 32'h00000104, 32'h0, 1'b1, 32'h00000104);
      step();
      op("b2b_csr", WB_SEL_CSR, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0000DEAD, 1'b1, 32'h0000DEAD);
      step();
      in_valid = 1'b0;
      step();

      in_wb_sel    = WB_SEL_MEM;
      in_reg_write = 1'b1;
      in_rd        = 5'd13;
      in_funct3    = F3_LW;
      in_alu_out   = 32'h3000;
      in_valid     = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_pending", load_pending, 1);
      step();
      rst_n   = 1'b0;
      ret_cnt = 0;
      #2;
      chk("rstmid_we", rf_we, 0);
      chk("rstmid_pending_clr", load_pending, 0);
      chk("rstmid_load_rd", load_rd, 0);
`ifdef WB_INSTRET_EN
      chk("rstmid_instret", instret, 0);
`endif
      step();
      rst_n = 1'b1;
      step();
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = 32'h7777;
      @(negedge clk);
      chk("post_rst_we", rf_we, 0);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_pending", load_pending, 0);
      step();
      dmem_rsp_valid = 1'b0;

      op("post_rst_alu", WB_SEL_ALU, 1'b1, 5'd14, 32'h00000077, 32'h0, 32'h0, 1'b1, 32'h00000077);
      step();
      in_valid = 1'b0;
      step();
      step();
`ifdef WB_INSTRET_EN
      chk("instret_after_rst", instret, 64'(ret_cnt));
`endif

      chk("sb_empty", 64'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
